// File: rtl/reg_writeback_pkg.sv
// Shared writeback definitions: FSM encoding, load FIFO geometry and entry layout.
package reg_writeback_pkg;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CNT_W = 2;
  localparam int REG_AW     = 5;
  localparam int XLEN       = 32;

  localparam logic [FIFO_CNT_W-1:0] FIFO_FULL = FIFO_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUEUED  = 2'd1,
    ST_STARVED = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_wb_fifo2.sv
// Two-entry in-order load queue; entries can be invalidated by destination register
// but still occupy their slot until dequeued.
module wb_fifo2
  import reg_writeback_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [REG_AW-1:0]     push_rd,
  input  logic [XLEN-1:0]       push_data,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [REG_AW-1:0]     kill_rd,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  head_vld,
  output logic [REG_AW-1:0]     head_rd,
  output logic [XLEN-1:0]       head_data,
  output logic [31:0]           vld_mask
);

  wb_entry_t             ent_q [FIFO_DEPTH];
  wb_entry_t             ent_d [FIFO_DEPTH];
  logic [FIFO_CNT_W-1:0] cnt_q;
  logic [FIFO_CNT_W-1:0] cnt_d;
  logic [FIFO_CNT_W-1:0] cnt_mid;

  always_comb begin
    ent_d   = ent_q;
    cnt_mid = cnt_q;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (kill_en && (ent_q[i].rd == kill_rd)) ent_d[i].vld = 1'b0;
    end
    // Pop shifts the (possibly killed) tail into the head slot.
    if (pop && (cnt_q != '0)) begin
      ent_d[0]     = ent_d[1];
      ent_d[1].vld = 1'b0;
      cnt_mid      = cnt_q - FIFO_CNT_W'(1);
    end
    cnt_d = cnt_mid;
    if (push && (cnt_mid < FIFO_FULL)) begin
      ent_d[cnt_mid[0]] = '{vld: 1'b1, rd: push_rd, data: push_data};
      cnt_d             = cnt_mid + FIFO_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) ent_q[i].vld <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < FIFO_DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

  always_comb begin
    vld_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_q[i].vld) vld_mask[ent_q[i].rd] = 1'b1;
    end
  end

  assign count     = cnt_q;
  assign head_vld  = ent_q[0].vld;
  assign head_rd   = ent_q[0].rd;
  assign head_data = ent_q[0].data;

endmodule

// File: rtl/reg_writeback.sv
// Merges ALU results and load returns onto one register-file write port, queueing
// loads that lose arbitration and stalling the ALU when a queued load starves.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              mem_valid,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_data,
  output logic              mem_ready,
  output logic              stall_req,
  output logic              reg_write,
  output logic [REG_AW-1:0] write_reg,
  output logic [XLEN-1:0]   write_data,
  output logic [31:0]       pending_mask
);

  localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  wb_state_e             state_q;
  wb_state_e             state_d;
  logic [CNT_W-1:0]      starve_q;
  logic [CNT_W-1:0]      starve_d;
  logic [FIFO_CNT_W-1:0] fifo_cnt;
  logic [FIFO_CNT_W-1:0] cnt_nxt;
  logic                  head_vld;
  logic [REG_AW-1:0]     head_rd;
  logic [XLEN-1:0]       head_data;
  logic                  accept;
  logic                  alu_kill;
  logic                  pop;
  logic                  bypass;
  logic                  push;
  logic                  wr_en_p0;
  logic [REG_AW-1:0]     wr_rd_p0;
  logic [XLEN-1:0]       wr_data_p0;

  assign mem_ready = (fifo_cnt < FIFO_FULL);
  assign accept    = mem_valid && mem_ready;
  assign alu_kill  = alu_valid && (alu_rd != '0);
  assign pop       = !alu_valid && (fifo_cnt != '0);
  assign bypass    = !alu_valid && (fifo_cnt == '0) && accept;
  // The load is older than a same-cycle ALU write to the same register, so it is dropped.
  assign push      = accept && !bypass && (mem_rd != '0) &&
                     !(alu_kill && (mem_rd == alu_rd));

  wb_fifo2 u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_rd   (mem_rd),
    .push_data (mem_data),
    .pop       (pop),
    .kill_en   (alu_kill),
    .kill_rd   (alu_rd),
    .count     (fifo_cnt),
    .head_vld  (head_vld),
    .head_rd   (head_rd),
    .head_data (head_data),
    .vld_mask  (pending_mask)
  );

  always_comb begin
    wr_en_p0   = 1'b0;
    wr_rd_p0   = '0;
    wr_data_p0 = '0;
    if (alu_valid) begin
      wr_en_p0   = (alu_rd != '0);
      wr_rd_p0   = alu_rd;
      wr_data_p0 = alu_data;
    end else if (fifo_cnt != '0) begin
      wr_en_p0   = head_vld && (head_rd != '0);
      wr_rd_p0   = head_rd;
      wr_data_p0 = head_data;
    end else if (bypass) begin
      wr_en_p0   = (mem_rd != '0);
      wr_rd_p0   = mem_rd;
      wr_data_p0 = mem_data;
    end
  end

  always_comb begin
    cnt_nxt  = fifo_cnt + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
    starve_d = '0;
    if ((fifo_cnt != '0) && !pop) begin
      starve_d = (starve_q == LIMIT_C) ? starve_q : starve_q + CNT_W'(1);
    end
    if (cnt_nxt == '0)           state_d = ST_IDLE;
    else if (starve_d >= LIMIT_C) state_d = ST_STARVED;
    else                          state_d = ST_QUEUED;
  end

  // Stage p0 -> registered write port and control state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      starve_q   <= '0;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      reg_write  <= wr_en_p0;
      write_reg  <= wr_rd_p0;
      write_data <= wr_data_p0;
    end
  end

  assign stall_req = (state_q == ST_STARVED);

endmodule

// File: tb/tb_reg_writeback.sv
// Directed vector bench for reg_writeback: one row per clock, expected outputs after the edge.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        stall_req;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] pending_mask;

  int tests = 0;
  int fails = 0;

  reg_writeback #(.STARVE_LIMIT(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .stall_req    (stall_req),
    .reg_write    (reg_write),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .pending_mask (pending_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] mdat;
    logic        e_rw;
    logic [4:0]  e_rd;
    logic [31:0] e_dat;
    logic        e_rdy;
    logic        e_stall;
    logic [31:0] e_pend;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                     input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
                     input logic e_rw, input logic [4:0] e_rd, input logic [31:0] e_dat,
                     input logic e_rdy, input logic e_stall, input logic [31:0] e_pend);
    vec_t v;
    v = '{av, ard, adat, mv, mrd, mdat, e_rw, e_rd, e_dat, e_rdy, e_stall, e_pend};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    mem_valid = mv; mem_rd = mrd; mem_data = mdat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   alu: v rd data         mem: v rd data      exp: rw rd data        rdy stall pend
    add(1, 5, 32'hDEADBEEF,  0, 0, 0,           1, 5, 32'hDEADBEEF,  1, 0, 32'h0);
    add(0, 0, 0,             0, 0, 0,           0, 0, 0,             1, 0, 32'h0);
    add(1, 3, 32'h11,        1, 7, 32'h22,      1, 3, 32'h11,        1, 0, 32'h80);
    add(0, 0, 0,             0, 0, 0,           1, 7, 32'h22,        1, 0, 32'h0);
    add(0, 0, 0,             0, 0, 0,           0, 0, 0,             1, 0, 32'h0);
    add(1, 1, 32'h1,         1, 9, 32'hAAAA,    1, 1, 32'h1,         1, 0, 32'h200);
    add(1, 9, 32'hBBBB,      0, 0, 0,           1, 9, 32'hBBBB,      1, 0, 32'h0);
    add(0, 0, 0,             0, 0, 0,           0, 0, 0,             1, 0, 32'h0);
    add(0, 0, 0,             0, 0, 0,           0, 0, 0,             1, 0, 32'h0);
    add(1, 2, 32'h2,         1, 4, 32'h44,      1, 2, 32'h2,         1, 0, 32'h10);
    add(1, 2, 32'h3,         0, 0, 0,           1, 2, 32'h3,         1, 0, 32'h10);
    add(1, 2, 32'h4,         0, 0, 0,           1, 2, 32'h4,         1, 0, 32'h10);
    add(1, 2, 32'h5,         0, 0, 0,           1, 2, 32'h5,         1, 0, 32'h10);
    add(1, 2, 32'h6,         0, 0, 0,           1, 2, 32'h6,         1, 1, 32'h10);
    add(1, 6, 32'h7,         0, 0, 0,           1, 6, 32'h7,         1, 1, 32'h10);
    add(0, 0, 0,             0, 0, 0,           1, 4, 32'h44,        1, 0, 32'h0);
    add(0, 0, 0,             0, 0, 0,           0, 0, 0,             1, 0, 32'h0);
    add(1, 1, 32'h10,        1, 10, 32'hA0,     1, 1, 32'h10,        1, 0, 32'h400);
    add(1, 1, 32'h11,        1, 11, 32'hB0,     1, 1, 32'h11,        0, 0, 32'hC00);
    add(1, 1, 32'h12,        1, 12, 32'hC0,     1, 1, 32'h12,        0, 0, 32'hC00);
    add(0, 0, 0,             1, 12, 32'hC0,     1, 10, 32'hA0,       1, 0, 32'h800);
    add(0, 0, 0,             1, 12, 32'hC0,     1, 11, 32'hB0,       1, 0, 32'h1000);
    add(0, 0, 0,             0, 0, 0,           1, 12, 32'hC0,       1, 0, 32'h0);
    add(0, 0, 0,             1, 0, 32'h55,      0, 0, 0,             1, 0, 32'h0);
    add(1, 1, 32'h20,        1, 0, 32'h66,      1, 1, 32'h20,        1, 0, 32'h0);
    add(0, 0, 0,             0, 0, 0,           0, 0, 0,             1, 0, 32'h0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst_write_reg", {27'd0, write_reg}, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_pending", pending_mask, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_mem_ready", {31'd0, mem_ready}, 32'd1);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].av, vecs[i].ard, vecs[i].adat, vecs[i].mv, vecs[i].mrd, vecs[i].mdat);
      tick();
      chk($sformatf("v%0d_reg_write", i), {31'd0, reg_write}, {31'd0, vecs[i].e_rw});
      if (vecs[i].e_rw) begin
        chk($sformatf("v%0d_write_reg", i), {27'd0, write_reg}, {27'd0, vecs[i].e_rd});
        chk($sformatf("v%0d_write_data", i), write_data, vecs[i].e_dat);
      end
      chk($sformatf("v%0d_mem_ready", i), {31'd0, mem_ready}, {31'd0, vecs[i].e_rdy});
      chk($sformatf("v%0d_stall", i), {31'd0, stall_req}, {31'd0, vecs[i].e_stall});
      chk($sformatf("v%0d_pending", i), pending_mask, vecs[i].e_pend);
    end

    // Reset with two loads queued behind ALU traffic: nothing may be written afterwards.
    drive(1, 1, 32'h30, 1, 13, 32'hD0);
    tick();
    drive(1, 1, 32'h31, 1, 14, 32'hE0);
    tick();
    chk("mid_pending_before", pending_mask, 32'h6000);
    chk("mid_ready_before", {31'd0, mem_ready}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("mid_rst_pending", pending_mask, 32'd0);
    chk("mid_rst_ready", {31'd0, mem_ready}, 32'd1);
    chk("mid_rst_stall", {31'd0, stall_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid_post%0d_reg_write", i), {31'd0, reg_write}, 32'd0);
      chk($sformatf("mid_post%0d_pending", i), pending_mask, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 The block SHALL have one parameter: STARVE_LIMIT, default 4, meaning the number of consecutive cycles a queued load may wait before stall_req is raised.
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present this cycle; cannot be back-pressured.
- alu_rd  in  5  ALU destination register.
- alu_data  in  32  ALU result.
- mem_valid  in  1  load result offered.
- mem_rd  in  5  load destination register.
- mem_data  in  32  load data.
- mem_ready  out  1  load accepted when mem_valid & mem_ready at posedge.
- stall_req  out  1  upstream SHALL hold alu_valid low in any cycle stall_req is high.
- reg_write  out  1  register-file write enable.
- write_reg  out  5  register-file write address.
- write_data  out  32  register-file write data.
- pending_mask  out  32  bit i set while a load to register i is queued.

Function
REQ-003 The block SHALL merge the ALU and load sources onto the single register-file write port and emit at most one write per cycle.
REQ-004 reg_write, write_reg and write_data SHALL be registered, so a write selected at edge N appears after edge N and commits into the register file at edge N+1.
REQ-005 Source priority at each edge SHALL be: ALU (if alu_valid), then the load FIFO head, then a load bypassed directly from the mem inputs when the FIFO is empty; the lowest-priority valid source wins only if no higher-priority source is valid.
REQ-006 A load that is accepted but not selected SHALL be enqueued in a 2-entry in-order FIFO.
REQ-007 mem_ready SHALL equal (FIFO count < 2), computed combinationally from the registered count; there is no enqueue into a full FIFO, even if it drains in the same cycle.
REQ-008 Any write with rd = 0 (either source) SHALL be discarded: no reg_write pulse, no FIFO entry, no pending_mask bit.
REQ-009 WAW ordering: when alu_valid and alu_rd = r (r != 0), every queued load entry to r SHALL be invalidated, and a same-cycle accepted load to r SHALL be dropped. The load is treated as older than the ALU result.
REQ-010 Invalidated FIFO entries SHALL still be dequeued in order but SHALL produce reg_write = 0 in their slot.
REQ-011 pending_mask SHALL reflect valid FIFO entries after each edge, and SHALL clear in the same edge on which an entry is dequeued or invalidated.
REQ-012 A starvation counter SHALL increment on each edge where the FIFO is non-empty and the head was not dequeued, and SHALL clear otherwise.
REQ-013 When the starvation counter reaches STARVE_LIMIT, stall_req SHALL be registered high and SHALL stay high until the edge on which the head is dequeued.
REQ-014 If alu_valid = 1 while stall_req = 1 (protocol violation), the ALU SHALL still win arbitration; the block SHALL NOT corrupt or lose FIFO state.
REQ-015 Control SHALL be a three-state FSM:
- IDLE: FIFO empty.
- QUEUED: FIFO non-empty, counter < limit.
- STARVED: stall_req high.
- Transitions: IDLE->QUEUED on enqueue; QUEUED->STARVED at the limit; QUEUED/STARVED->IDLE when the last entry drains; STARVED->QUEUED when the head drains with the FIFO still non-empty.

Reset
REQ-016 While reset is high at a posedge, the block SHALL flush the FIFO and drop any in-flight entries, and SHALL drive reg_write=0, write_reg=0, write_data=0, pending_mask=0, stall_req=0, counter=0, state=IDLE, mem_ready=1.
REQ-017 Reset asserted mid-operation SHALL discard queued loads without emitting any write.

Structure
REQ-018 The FSM state encoding, FIFO depth (2) and register-address width (5) SHALL live in a shared processor package.
REQ-019 The FIFO SHALL be a sub-module named wb_fifo2, with entries {valid, rd, data}, push/pop, count, and a per-entry kill-by-rd input.

Verification
REQ-020 ALU-only: alu_valid with rd=5, data=0xDEADBEEF -> reg_write=1, write_reg=5, write_data=0xDEADBEEF one cycle later.
REQ-021 Collision: ALU (rd=3, 0x11) and load (rd=7, 0x22) in the same cycle -> rd 3 written at cycle+1, rd 7 at cycle+2; pending_mask bit 7 is high for one cycle.
REQ-022 WAW: load rd=9 (0xAAAA) queued, then ALU rd=9 (0xBBBB) -> only 0xBBBB is written; pending_mask[9] clears; the slot of the killed entry has reg_write=0.
REQ-023 Starvation: load queued, then alu_valid held high for 4 cycles -> stall_req=1; after alu_valid drops, the load is written next cycle and stall_req=0.
REQ-024 Full FIFO and x0:
- Two loads queued under ALU traffic -> mem_ready=0; a third load is held off until the FIFO drains.
- A load with rd=0 produces no write.
REQ-025 Reset mid-operation: reset with two queued loads -> no writes emitted, pending_mask=0, mem_ready=1 on the following cycle.
